// File: rtl/bitrev_obi_drain.sv
// Bit-reversal drain: buffers the bit-reversed sample stream in a small FIFO,
// exposes it to the core through a four-register OBI subordinate, counts
// 2^K-sample frames at push time and raises a level frame-done interrupt.

package bitrev_obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32'd32, DataWidth: 32'd32, IdWidth: 32'd4};

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } sbr_obi_rsp_t;

endpackage

module bitrev_obi_drain
  import bitrev_obi_pkg::*;
#(
  parameter int unsigned K         = 6,
  parameter int unsigned DW        = 32,
  parameter int unsigned FifoDepth = 4,
  parameter obi_cfg_t    ObiCfg    = SbrObiCfg,
  parameter type         obi_req_t = sbr_obi_req_t,
  parameter type         obi_rsp_t = sbr_obi_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  input  obi_req_t      obi_req_i,
  output obi_rsp_t      obi_rsp_o,
  output logic          irq_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdW  = ObiCfg.IdWidth;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegFrames = 2'd3;

  // Sample storage and bookkeeping
  logic [DW-1:0]   mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [K-1:0]    idx_q, idx_d;
  logic [31:0]     frames_q, frames_d;

  // Control and status
  logic enable_q, enable_d;
  logic irq_en_q, irq_en_d;
  logic ovf_q, ovf_d;
  logic fd_q, fd_d;
  logic irq_q, irq_d;

  // Registered OBI response
  logic           rvalid_q, rvalid_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [IdW-1:0] rid_q, rid_d;

  // Decoded request / stream events
  logic [1:0]  sel_s;
  logic        rd_s, wr_s, ctrl_wr_s, clear_s;
  logic        full_s, empty_s, push_s, pop_s, ovf_set_s, fd_set_s;
  logic [31:0] status_s, head_s, rdata_s;
  logic        unused_obi_s;

  assign unused_obi_s = ^{obi_req_i.addr[31:4], obi_req_i.addr[1:0],
                          obi_req_i.wdata[31:5], obi_req_i.be[3:1]};

  // Request decode, stream handshake and register read mux
  always_comb begin
    sel_s     = obi_req_i.addr[3:2];
    rd_s      = obi_req_i.req && !obi_req_i.we;
    wr_s      = obi_req_i.req && obi_req_i.we;
    ctrl_wr_s = wr_s && (sel_s == RegCtrl) && obi_req_i.be[0];
    clear_s   = ctrl_wr_s && obi_req_i.wdata[2];
    full_s    = (count_q == CntW'(FifoDepth));
    empty_s   = (count_q == CntW'(0));
    // ready is evaluated before any pop, so a full FIFO blocks even while popping
    ready_o   = enable_q && !full_s && !clear_s;
    push_s    = valid_i && ready_o;
    pop_s     = rd_s && (sel_s == RegData) && !empty_s && !clear_s;
    ovf_set_s = valid_i && enable_q && full_s;
    fd_set_s  = push_s && (idx_q == {K{1'b1}});

    head_s = 32'd0;
    if (!empty_s) begin
      head_s[DW-1:0] = mem_q[rd_ptr_q];
    end else begin
      head_s = 32'd0;
    end

    status_s        = 32'd0;
    status_s[0]     = empty_s;
    status_s[1]     = full_s;
    status_s[2]     = ovf_q;
    status_s[3]     = fd_q;
    status_s[7:4]   = 4'(count_q);
    status_s[31:16] = 16'(idx_q);

    case (sel_s)
      RegData:   rdata_s = head_s;
      RegStatus: rdata_s = status_s;
      RegCtrl:   rdata_s = {30'd0, irq_en_q, enable_q};
      RegFrames: rdata_s = frames_q;
      default:   rdata_s = 32'd0;
    endcase
  end

  // Next-state for FIFO pointers, counters, control and stickies
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;

    if (clear_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        idx_d    = idx_q + K'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    if (fd_set_s) begin
      frames_d = frames_q + 32'd1;
    end else begin
      frames_d = frames_q;
    end

    // a set event in the same cycle as its w1c wins, so no event is lost
    if (ctrl_wr_s) begin
      enable_d = obi_req_i.wdata[0];
      irq_en_d = obi_req_i.wdata[1];
      ovf_d    = (ovf_q && !obi_req_i.wdata[3]) || ovf_set_s;
      fd_d     = (fd_q && !obi_req_i.wdata[4]) || fd_set_s;
    end else begin
      ovf_d    = ovf_q || ovf_set_s;
      fd_d     = fd_q || fd_set_s;
    end

    irq_d = irq_en_q && fd_q;
  end

  // Next-state for the one-cycle-latency OBI response
  always_comb begin
    rvalid_d = obi_req_i.req;
    rid_d    = obi_req_i.aid;
    if (wr_s) begin
      rdata_d = 32'd0;
      err_d   = (sel_s != RegCtrl);
    end else begin
      rdata_d = rdata_s;
      err_d   = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      frames_q <= 32'd0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      fd_q     <= fd_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rid_q    <= rid_d;
    end
  end

  // Sample storage write; contents are qualified by the fill count, so no reset
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Response and interrupt outputs, all driven from registers except gnt
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
    irq_o            = irq_q;
  end

endmodule
